// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS register file types, constants and word mux helper
//
// Purpose : common definitions for the register file slice.
//   REG_ADDR_W / REG_DATA_W : register number width and register width
//   REG_ZERO                : hardwired-zero register number ($0)
//   reg_addr_t / word_t     : register number and data word types
//   word_mux2               : 32-bit 2:1 word mux used as the read tree element
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // sel=0 picks a, sel=1 picks b.
  function automatic word_t word_mux2(input logic sel, input word_t a, input word_t b);
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/reg_word.sv
// rtl/reg_word.sv - enabled D flip-flop bank holding one register word
//
// Purpose : one general-purpose register, cleared by asynchronous reset.
// Ports   :
//   clk      in  rising-edge clock
//   reset_n  in  asynchronous active-low reset, clears q to 0
//   en       in  load enable, d is captured at posedge clk when high
//   d        in  DATA_W load data
//   q        out DATA_W stored word
module reg_word
  import mips_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/reg_file_32x32.sv
// rtl/reg_file_32x32.sv - MIPS 32x32 register file, two read ports, one write port
//
// Purpose : general-purpose register file with hardwired $0 and write-through
//           bypass so a WB-stage write is visible to ID in the same cycle.
// Ports   :
//   clk      in  rising-edge clock
//   reset_n  in  asynchronous active-low reset, clears registers 1..31
//   we       in  write enable, sampled at posedge clk
//   waddr    in  ADDR_W write register number
//   wdata    in  DATA_W write data
//   raddr1   in  ADDR_W read port 1 register number (rs)
//   raddr2   in  ADDR_W read port 2 register number (rt)
//   rdata1   out DATA_W read port 1 data (combinational)
//   rdata2   out DATA_W read port 2 data (combinational)
module reg_file_32x32
  import mips_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  // Register words; entry 0 is a constant so $0 has no storage.
  word_t rf [32];

  // One-hot write enables for registers 1..31; $0 has no enable at all.
  logic [31:1] wen;

  always_comb begin
    wen = '0;
    for (int i = 1; i < 32; i++) begin
      wen[i] = we && (waddr == reg_addr_t'(i));
    end
  end

  assign rf[0] = '0;

  for (genvar r = 1; r < 32; r++) begin : g_reg
    reg_word #(.DATA_W(DATA_W)) u_reg_word (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (wen[r]),
      .d       (wdata),
      .q       (rf[r])
    );
  end

  reg_addr_t ra [2];
  word_t     rd [2];

  assign ra[0] = raddr1;
  assign ra[1] = raddr2;

  for (genvar p = 0; p < 2; p++) begin : g_port
    word_t m16 [16];
    word_t m8  [8];
    word_t m4  [4];
    word_t m2  [2];
    word_t sel;
    logic  bypass;

    // Binary 2:1 tree, LSB of the address selects at the leaves.
    for (genvar i = 0; i < 16; i++) begin : g_l1
      assign m16[i] = word_mux2(ra[p][0], rf[2*i], rf[2*i+1]);
    end
    for (genvar i = 0; i < 8; i++) begin : g_l2
      assign m8[i] = word_mux2(ra[p][1], m16[2*i], m16[2*i+1]);
    end
    for (genvar i = 0; i < 4; i++) begin : g_l3
      assign m4[i] = word_mux2(ra[p][2], m8[2*i], m8[2*i+1]);
    end
    for (genvar i = 0; i < 2; i++) begin : g_l4
      assign m2[i] = word_mux2(ra[p][3], m4[2*i], m4[2*i+1]);
    end
    assign sel = word_mux2(ra[p][4], m2[0], m2[1]);

    // Same-cycle forwarding of the pending write; never for $0.
    assign bypass = we && (waddr == ra[p]) && (ra[p] != REG_ZERO);

    // Gating on reset_n keeps the bypass path from leaking wdata during reset.
    assign rd[p] = !reset_n          ? '0    :
                   bypass            ? wdata :
                   (ra[p] == REG_ZERO) ? '0  : sel;
  end

  assign rdata1 = rd[0];
  assign rdata2 = rd[1];

endmodule

// File: tb/tb_reg_file_32x32.sv
// tb/tb_reg_file_32x32.sv - directed self-checking bench for reg_file_32x32
module tb_reg_file_32x32;

  logic        clk;
  logic        reset_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  int vectors;
  int miscompares;

  reg_file_32x32 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr1  (raddr1),
    .raddr2  (raddr2),
    .rdata1  (rdata1),
    .rdata2  (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single write: set up at negedge, captured at posedge, then idle.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    @(posedge clk);
    #1;
    we    = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n = 1'b0;
    we      = 1'b0;
    waddr   = 5'd0;
    wdata   = 32'h0;
    raddr1  = 5'd1;
    raddr2  = 5'd31;

    // Reset state
    #12;
    chk("reset_rd1", rdata1, 32'h0);
    chk("reset_rd2", rdata2, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Write 8, read back; 9 stays 0
    wr(5'd8, 32'hDEADBEEF);
    raddr1 = 5'd8;
    raddr2 = 5'd9;
    #1;
    chk("wr8_rd1", rdata1, 32'hDEADBEEF);
    chk("rd9_rd2", rdata2, 32'h0);

    // $0 protection, same cycle and after the edge
    @(negedge clk);
    we     = 1'b1;
    waddr  = 5'd0;
    wdata  = 32'hFFFFFFFF;
    raddr1 = 5'd0;
    raddr2 = 5'd0;
    #1;
    chk("zero_pre_rd1", rdata1, 32'h0);
    chk("zero_pre_rd2", rdata2, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    chk("zero_post_rd1", rdata1, 32'h0);
    chk("zero_post_rd2", rdata2, 32'h0);

    // Bypass on 31 over a previous value of 1
    wr(5'd31, 32'h1);
    @(negedge clk);
    we     = 1'b1;
    waddr  = 5'd31;
    wdata  = 32'h12345678;
    raddr1 = 5'd31;
    raddr2 = 5'd8;
    #1;
    chk("bypass_rd1", rdata1, 32'h12345678);
    chk("bypass_other_rd2", rdata2, 32'hDEADBEEF);
    we = 1'b0;
    #1;
    chk("nobypass_rd1", rdata1, 32'h1);

    // Dual port on 5; write to 6 does not disturb 5
    wr(5'd5, 32'hA5A5A5A5);
    raddr1 = 5'd5;
    raddr2 = 5'd5;
    #1;
    chk("dual_rd1", rdata1, 32'hA5A5A5A5);
    chk("dual_rd2", rdata2, 32'hA5A5A5A5);
    @(negedge clk);
    we    = 1'b1;
    waddr = 5'd6;
    wdata = 32'h00000066;
    #1;
    chk("w6_pre_rd1", rdata1, 32'hA5A5A5A5);
    chk("w6_pre_rd2", rdata2, 32'hA5A5A5A5);
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    chk("w6_post_rd1", rdata1, 32'hA5A5A5A5);
    chk("w6_post_rd2", rdata2, 32'hA5A5A5A5);
    raddr2 = 5'd6;
    #1;
    chk("rd6_rd2", rdata2, 32'h00000066);

    // Mid-run reset with registers loaded: outputs clear before any clock
    @(negedge clk);
    raddr1 = 5'd8;
    raddr2 = 5'd31;
    #1;
    chk("preload_rd1", rdata1, 32'hDEADBEEF);
    reset_n = 1'b0;
    #1;
    chk("midrst_rd1", rdata1, 32'h0);
    chk("midrst_rd2", rdata2, 32'h0);
    we    = 1'b1;
    waddr = 5'd8;
    wdata = 32'hCAFEF00D;
    #1;
    chk("midrst_bypass_rd1", rdata1, 32'h0);
    @(negedge clk);
    we      = 1'b0;
    reset_n = 1'b1;
    for (int r = 1; r < 32; r++) begin
      raddr1 = 5'(r);
      raddr2 = 5'(32 - r);
      #1;
      chk($sformatf("postrst_rd1_r%0d", r), rdata1, 32'h0);
      chk($sformatf("postrst_rd2_r%0d", 32 - r), rdata2, 32'h0);
    end

    // Reset race: write to 3 pending when reset asserts is dropped
    @(negedge clk);
    we     = 1'b1;
    waddr  = 5'd3;
    wdata  = 32'h00000077;
    raddr1 = 5'd0;
    raddr2 = 5'd0;
    #2;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    we = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    raddr1  = 5'd3;
    #1;
    chk("race_rd1", rdata1, 32'h0);

    // First write after release is honoured at the first posedge
    we    = 1'b1;
    waddr = 5'd3;
    wdata = 32'h00000077;
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    chk("first_wr_rd1", rdata1, 32'h00000077);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
